// File: rtl/timing_seq_pkg.sv
// timing_seq_pkg: shared FSM encoding, width helper and default depth for the T-state sequencer
package timing_seq_pkg;
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_t;
  localparam int DEFAULT_DEPTH = 8;
  function automatic int calc_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/seq_onehot_decoder.sv
// seq_onehot_decoder: registered one-hot decode of the sequencer's next count
module seq_onehot_decoder
  import timing_seq_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int RESET_VAL = 0,
  parameter int W         = calc_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     i_val,
  output logic [DEPTH-1:0] o_t
);
  localparam logic [DEPTH-1:0] LP_RST_T = DEPTH'(1) << RESET_VAL;
  logic [DEPTH-1:0] r_t;
  // decode the value sc is about to take so t lands on the same edge as sc
  always_ff @(posedge clk) begin
    r_t <= rst ? LP_RST_T : DEPTH'(1) << i_val;
  end
  assign o_t = r_t;
endmodule

// File: rtl/timing_sequencer.sv
// timing_sequencer: T-state counter with clr/load/inc, halt/resume and wrap; one-hot t gated by TIMING_SEQUENCER_DECODE_EN
module timing_sequencer
  import timing_seq_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int RESET_VAL = 0,
  localparam int W        = calc_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic             halt_req,
  input  logic             resume,
  output logic [W-1:0]     sc,
  output logic [DEPTH-1:0] t,
  output logic             wrap,
  output logic             halted,
  output logic             load_err
);
  localparam logic [W-1:0] LP_LAST  = W'(DEPTH - 1);
  localparam logic [W-1:0] LP_RST   = W'(RESET_VAL);
  localparam logic [W:0]   LP_DEPTH = (W + 1)'(DEPTH);
  seq_state_t r_state, w_state_nxt;
  logic [W-1:0] r_sc, w_sc_nxt;
  logic r_wrap, r_load_err;
  logic w_wrap_nxt, w_load_err_nxt, w_inc_ok, w_load_bad;
  // resume wins over halt_req, so both together always lands in RUN
  always_comb begin
    w_state_nxt = resume ? RUN : (halt_req ? HALTED : r_state);
  end
  // count update with priority clr > load > inc; the halting cycle holds sc
  always_comb begin
    w_inc_ok       = inc && (r_state == RUN) && !halt_req;
    w_load_bad     = {1'b0, load_val} >= LP_DEPTH;
    w_wrap_nxt     = !clr && !load && w_inc_ok && (r_sc == LP_LAST);
    w_load_err_nxt = !clr && load && w_load_bad;
    w_sc_nxt       = rst ? LP_RST :
                     clr ? '0 :
                     load ? (w_load_bad ? '0 : load_val) :
                     w_inc_ok ? ((r_sc == LP_LAST) ? '0 : r_sc + 1'b1) :
                     r_sc;
  end
  // state, count and one-cycle flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_sc       <= LP_RST;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sc       <= w_sc_nxt;
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end
  assign sc       = r_sc;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;
  assign halted   = (r_state == HALTED);
`ifdef TIMING_SEQUENCER_DECODE_EN
  seq_onehot_decoder #(
    .DEPTH    (DEPTH),
    .RESET_VAL(RESET_VAL),
    .W        (W)
  ) u_dec (
    .clk  (clk),
    .rst  (rst),
    .i_val(w_sc_nxt),
    .o_t  (t)
  );
`else
  assign t = '0;
`endif
endmodule
